mem_stage_access: RTL and testbench

- Consumer of the EX/MEM pipeline register outputs: MemRead, MemWrite, MemtoReg, RegWrite, ALUout, RegWriteDst and PC+4.
- Performs the data-memory access over a req/ack bus and stalls the pipeline while the access is outstanding.
- Selects the writeback value and registers it into the MEM/WB stage.
- Sits between EX/MEM and the register file write port.

---
 rtl/mem_stage_access.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_stage_access.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access.sv
// ============================================================================
// Module   : mem_stage_access
// Purpose  : MEM pipeline stage. It consumes the EX/MEM register outputs. For
//            loads and stores it performs the data-memory access over a
//            req/ack bus and stalls the upstream pipeline until the access
//            completes. It then selects the writeback value and registers it
//            into the MEM/WB stage.
// Ports    : clk, reset           - clock, asynchronous active-high reset
//            mem_read/mem_write   - load/store request from EX/MEM
//            alu_out, store_data  - address (or ALU result) and store data
//            reg_write_in, memtoreg_in, rd_in, pc_plus4_in - writeback control
//            bus_req/we/addr/wdata, bus_ack, bus_rdata     - memory bus
//            stall                - freezes PC, IF/ID, ID/EX and EX/MEM
//            wb_reg_write, wb_rd, wb_data - registered MEM/WB outputs
//            align_err, bus_err   - one-cycle error pulses
// Options  : MEM_TIMEOUT_EN - when defined, a BUSY access with no ack for
//            TIMEOUT_CYCLES cycles is aborted and bus_err pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_access #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       store_data,
  input  logic              reg_write_in,
  input  logic [1:0]        memtoreg_in,
  input  logic [4:0]        rd_in,
  input  logic [31:0]       pc_plus4_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              stall,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              align_err,
  output logic              bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              align_err_q, align_err_d;
  logic [31:0]       rdata_q, rdata_d;
  // Writeback control captured when the access starts, replayed in DONE.
  logic              lat_reg_write_q, lat_reg_write_d;
  logic [1:0]        lat_memtoreg_q, lat_memtoreg_d;
  logic [4:0]        lat_rd_q, lat_rd_d;
  logic [31:0]       lat_alu_q, lat_alu_d;
  logic [31:0]       lat_pc4_q, lat_pc4_d;

  logic access;
  logic aligned;
  logic timeout;

  assign access  = mem_read | mem_write;
  assign aligned = (alu_out[1:0] == 2'b00);

  function automatic logic [31:0] wb_mux(input logic [1:0]  sel,
                                         input logic [31:0] alu,
                                         input logic [31:0] mem,
                                         input logic [31:0] pc4);
    case (sel)
      2'b01:   wb_mux = mem;
      2'b10:   wb_mux = pc4;
      default: wb_mux = alu;
    endcase
  endfunction

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // Counter reads 0 in the first BUSY cycle, so the limit is hit in the
  // TIMEOUT_CYCLES-th BUSY cycle.
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // An ack arriving on the limit cycle wins over the timeout.
  assign timeout = (state_q == S_BUSY) && !bus_ack && (cnt_q == LIMIT_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= timeout;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (access && aligned) state_d = S_BUSY;
      S_BUSY:  if (bus_ack || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    stall           = 1'b0;
    bus_req_d       = bus_req_q;
    bus_we_d        = bus_we_q;
    bus_addr_d      = bus_addr_q;
    bus_wdata_d     = bus_wdata_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    align_err_d     = 1'b0;
    rdata_d         = rdata_q;
    lat_reg_write_d = lat_reg_write_q;
    lat_memtoreg_d  = lat_memtoreg_q;
    lat_rd_d        = lat_rd_q;
    lat_alu_d       = lat_alu_q;
    lat_pc4_d       = lat_pc4_q;

    case (state_q)
      S_IDLE: begin
        if (access && aligned) begin
          // Stall in this same cycle so EX/MEM holds the instruction.
          stall           = 1'b1;
          bus_req_d       = 1'b1;
          bus_we_d        = mem_write & ~mem_read;  // reads take priority
          bus_addr_d      = ADDR_W'(alu_out);
          bus_wdata_d     = store_data;
          lat_reg_write_d = reg_write_in;
          lat_memtoreg_d  = memtoreg_in;
          lat_rd_d        = rd_in;
          lat_alu_d       = alu_out;
          lat_pc4_d       = pc_plus4_in;
          wb_reg_write_d  = 1'b0;
        end else begin
          // Plain ALU op, or a misaligned access squashed to a bubble.
          align_err_d    = access;
          wb_reg_write_d = reg_write_in & ~access;
          wb_rd_d        = rd_in;
          wb_data_d      = wb_mux(memtoreg_in, alu_out, rdata_q, pc_plus4_in);
        end
      end
      S_BUSY: begin
        stall          = 1'b1;
        wb_reg_write_d = 1'b0;
        if (bus_ack) begin
          rdata_d   = bus_rdata;
          bus_req_d = 1'b0;
        end else if (timeout) begin
          bus_req_d       = 1'b0;
          rdata_d         = 32'hDEAD_BEEF;
          lat_reg_write_d = 1'b0;
        end
      end
      S_DONE: begin
        wb_reg_write_d = lat_reg_write_q;
        wb_rd_d        = lat_rd_q;
        wb_data_d      = wb_mux(lat_memtoreg_q, lat_alu_q, rdata_q, lat_pc4_q);
      end
      default: begin
        wb_reg_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      align_err_q     <= 1'b0;
      rdata_q         <= '0;
      lat_reg_write_q <= 1'b0;
      lat_memtoreg_q  <= '0;
      lat_rd_q        <= '0;
      lat_alu_q       <= '0;
      lat_pc4_q       <= '0;
    end else begin
      bus_req_q       <= bus_req_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      align_err_q     <= align_err_d;
      rdata_q         <= rdata_d;
      lat_reg_write_q <= lat_reg_write_d;
      lat_memtoreg_q  <= lat_memtoreg_d;
      lat_rd_q        <= lat_rd_d;
      lat_alu_q       <= lat_alu_d;
      lat_pc4_q       <= lat_pc4_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign align_err    = align_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_access.sv
// ============================================================================
// Module   : tb_mem_stage_access
// Purpose  : Self-checking bench for mem_stage_access. Single-cycle ops come
//            from a vector table; multi-cycle accesses, reset mid-access and
//            the optional timeout (MEM_TIMEOUT_EN) use directed sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_access;

  localparam int ADDR_W = 32;
  localparam int TMO    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_read, mem_write;
  logic [31:0]       alu_out, store_data;
  logic              reg_write_in;
  logic [1:0]        memtoreg_in;
  logic [4:0]        rd_in;
  logic [31:0]       pc_plus4_in;
  logic              bus_req, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;
  logic              stall;
  logic              wb_reg_write;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              align_err, bus_err;

  int checks   = 0;
  int failures = 0;

  mem_stage_access #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .alu_out(alu_out), .store_data(store_data),
    .reg_write_in(reg_write_in), .memtoreg_in(memtoreg_in),
    .rd_in(rd_in), .pc_plus4_in(pc_plus4_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [31:0] alu;
    logic        rw;
    logic [1:0]  mtr;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic        exp_stall;
    logic        exp_wbrw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_aerr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; alu_out = 0; store_data = 0;
    reg_write_in = 0; memtoreg_in = 0; rd_in = 0; pc_plus4_in = 0;
  endtask

  // Called at a negedge: drive one single-cycle op and check its result.
  task automatic apply_vec(input vec_t v);
    mem_read = v.rd_en; mem_write = v.wr_en; alu_out = v.alu;
    reg_write_in = v.rw; memtoreg_in = v.mtr; rd_in = v.rd; pc_plus4_in = v.pc4;
    #1;
    chk("vec_stall", stall, v.exp_stall);
    @(negedge clk);
    chk("vec_wb_reg_write", wb_reg_write, v.exp_wbrw);
    chk("vec_wb_rd", wb_rd, v.exp_rd);
    chk("vec_wb_data", wb_data, v.exp_data);
    chk("vec_align_err", align_err, v.exp_aerr);
    chk("vec_bus_req", bus_req, 0);
    chk("vec_bus_err", bus_err, 0);
  endtask

  // Called at a negedge: full access acked in BUSY cycle n.
  task automatic do_access(input logic rd_en, input logic wr_en,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic rw, input logic [1:0] mtr, input logic [4:0] rd,
                           input int n, input logic [31:0] rdata,
                           input logic exp_we, input logic exp_wbrw,
                           input logic [31:0] exp_data);
    mem_read = rd_en; mem_write = wr_en; alu_out = addr; store_data = wdata;
    reg_write_in = rw; memtoreg_in = mtr; rd_in = rd; pc_plus4_in = 32'h0000_0444;
    #1;
    chk("acc_idle_stall", stall, 1);
    chk("acc_idle_req", bus_req, 0);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1) begin
        // Changes while the access is outstanding must be ignored.
        mem_read = 0; mem_write = 0; alu_out = 32'hDEAD_0001; store_data = 32'h1;
        reg_write_in = 1; memtoreg_in = 2'b10; rd_in = 5'd1; pc_plus4_in = 32'h999;
      end
      chk("acc_busy_req", bus_req, 1);
      chk("acc_busy_stall", stall, 1);
      chk("acc_busy_addr", bus_addr, addr);
      chk("acc_busy_we", bus_we, exp_we);
      if (exp_we) chk("acc_busy_wdata", bus_wdata, wdata);
      if (i == n) begin
        bus_ack = 1; bus_rdata = rdata;
      end
    end
    @(negedge clk);
    bus_ack = 0; bus_rdata = 32'h0;
    chk("acc_done_req", bus_req, 0);
    chk("acc_done_stall", stall, 0);
    chk("acc_done_bubble", wb_reg_write, 0);
    @(negedge clk);
    chk("acc_wb_reg_write", wb_reg_write, exp_wbrw);
    chk("acc_wb_rd", wb_rd, rd);
    chk("acc_wb_data", wb_data, exp_data);
  endtask

  initial begin
    //           rd wr alu            rw mtr    rd     pc4     st wbrw erd   edata          aerr
    vecs[0] = '{0, 0, 32'h0000_1234, 1, 2'b00, 5'd5,  32'h10,  0, 1, 5'd5,  32'h0000_1234, 0};
    vecs[1] = '{0, 0, 32'h0000_0077, 1, 2'b10, 5'd31, 32'h40,  0, 1, 5'd31, 32'h0000_0040, 0};
    vecs[2] = '{0, 0, 32'hFFFF_0000, 1, 2'b11, 5'd3,  32'h50,  0, 1, 5'd3,  32'hFFFF_0000, 0};
    vecs[3] = '{1, 0, 32'h0000_0102, 1, 2'b00, 5'd9,  32'h60,  0, 0, 5'd9,  32'h0000_0102, 1};
    vecs[4] = '{0, 1, 32'h0000_0203, 0, 2'b00, 5'd4,  32'h70,  0, 0, 5'd4,  32'h0000_0203, 1};
    vecs[5] = '{0, 0, 32'h0000_0055, 0, 2'b00, 5'd7,  32'h80,  0, 0, 5'd7,  32'h0000_0055, 0};

    idle_inputs();
    bus_ack = 0; bus_rdata = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_align_err", align_err, 0);
    chk("rst_bus_err", bus_err, 0);
    reset = 0;

    for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

    // Misaligned pulse lasts exactly one cycle.
    idle_inputs();
    @(negedge clk);
    chk("align_err_pulse_end", align_err, 0);

    // Load, ack in the 3rd BUSY cycle.
    do_access(1, 0, 32'h100, 32'h0, 1, 2'b01, 5'd8, 3, 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D);
    // Store, ack in the 1st BUSY cycle.
    do_access(0, 1, 32'h200, 32'hA5A5_A5A5, 0, 2'b00, 5'd4, 1, 32'h0, 1, 0, 32'h200);
    apply_vec(vecs[1]);
    // Read and write both set: read wins.
    do_access(1, 1, 32'h300, 32'h5555_5555, 1, 2'b01, 5'd10, 1, 32'h1111_2222, 0, 1, 32'h1111_2222);

    // Reset in the middle of an access.
    idle_inputs();
    mem_read = 1; alu_out = 32'h400; reg_write_in = 1; memtoreg_in = 2'b01; rd_in = 5'd12;
    @(negedge clk);
    chk("rstmid_req_before", bus_req, 1);
    idle_inputs();
    #2 reset = 1;
    #1;
    chk("rstmid_req_drop", bus_req, 0);
    chk("rstmid_stall_drop", stall, 0);
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    bus_ack = 0;
    chk("late_ack_wb", wb_reg_write, 0);
    chk("late_ack_req", bus_req, 0);
    @(negedge clk);
    chk("late_ack_wb2", wb_reg_write, 0);
    chk("late_ack_stall", stall, 0);
    apply_vec(vecs[0]);

`ifdef MEM_TIMEOUT_EN
    idle_inputs();
    mem_read = 1; alu_out = 32'h500; reg_write_in = 1; memtoreg_in = 2'b01; rd_in = 5'd13;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      if (i == 1) idle_inputs();
      chk("tmo_busy_req", bus_req, 1);
      chk("tmo_busy_err", bus_err, 0);
    end
    @(negedge clk);
    chk("tmo_bus_err", bus_err, 1);
    chk("tmo_req", bus_req, 0);
    chk("tmo_stall", stall, 0);
    @(negedge clk);
    chk("tmo_bus_err_end", bus_err, 0);
    chk("tmo_wb_reg_write", wb_reg_write, 0);
    chk("tmo_wb_data", wb_data, 32'hDEAD_BEEF);
    apply_vec(vecs[2]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
